color_box_tracker: RTL and testbench
====================================

# color_box_tracker

Scans the live pixel stream from the camera path, classifies each pixel against a target-colour window, and tracks the extreme points (leftmost, rightmost, topmost, bottommost) of all matching pixels in the frame. At frame end it publishes four (x,y) extreme points plus a one-cycle `predict_valid` pulse. These outputs are the `left/right/up/down` and `predict_valid` inputs consumed by the game logic. When too few pixels match, every published coordinate is the NOT_FOUND sentinel 2023.

## Interface
- `H_ACTIVE`, default 640: pixels with x ≥ H_ACTIVE are ignored.
- `V_ACTIVE`, default 480: pixels with y ≥ V_ACTIVE are ignored.
- `R_MIN`, default 8'd150: match requires R ≥ R_MIN.
- `G_MAX`, default 8'd90: match requires G ≤ G_MAX.
- `B_MAX`, default 8'd90: match requires B ≤ B_MAX.
- `MIN_PIXELS`, default 20'd64: minimum matching-pixel count for a frame to count as "found".
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: the current x/y/i_rgb is an active pixel.
- `x`, in, 11: pixel column.
- `y`, in, 11: pixel row.
- `i_rgb`, in, 8×[2:0]: pixel colour, where [0]=R, [1]=G, [2]=B.
- `frame_end`, in, 1: single-cycle pulse after the last pixel of a frame.
- `left`, out, 11×[1:0]: leftmost match, where [0]=x, [1]=y.
- `right`, out, 11×[1:0]: rightmost match.
- `up`, out, 11×[1:0]: topmost match.
- `down`, out, 11×[1:0]: bottommost match.
- `predict_valid`, out, 1: one-cycle pulse when new extremes are published.
- `hit_count`, out, 20: matching-pixel count of the last published frame.

## Operation
- **Stage 1 (match stage):** register `hit = i_valid & x<H_ACTIVE & y<V_ACTIVE & R≥R_MIN & G≤G_MAX & B≤B_MAX`, together with x and y.
- **Accumulators:**
  - `cnt` is 20 bits and saturates at 2^20−1.
  - The working extremes are initialised per frame:
    - L.x = 11'h7FF.
    - R.x = 0.
    - U.y = 11'h7FF.
    - D.y = 0.
    - Partner coordinates = 0.
- **On a registered hit:**
  - `cnt++`.
  - If x < L.x, load L with (x,y).
  - If x > R.x, or this is the first hit of the frame, load R with (x,y).
  - If y < U.y, load U with (x,y).
  - If y > D.y, or this is the first hit of the frame, load D with (x,y).
  - All comparisons are strict, so on ties the first pixel in raster order wins.
- **States:**
  - S_SCAN: accumulate. On `frame_end` go to S_FLUSH.
  - S_FLUSH (1 cycle): the last in-flight stage-1 pixel is accumulated; go to S_PUBLISH.
  - S_PUBLISH (1 cycle):
    - If cnt ≥ MIN_PIXELS, load the outputs from the working extremes; otherwise load all 8 output coordinates with 11'd2023.
    - Set `hit_count` = cnt.
    - Pulse `predict_valid`.
    - Clear the accumulators.
    - Return to S_SCAN.
- Outputs hold their value between publishes.
- **Simultaneous events:**
  - A pixel with `i_valid` in the same cycle as `frame_end` belongs to the ending frame.
  - `frame_end` arriving in S_FLUSH or S_PUBLISH is ignored.
  - `i_valid` pixels in S_FLUSH or S_PUBLISH are dropped; the stage-1 register is cleared in S_PUBLISH.
- **Reset (including mid-frame):**
  - State = S_SCAN.
  - Accumulators cleared.
  - All output coordinates = 2023.
  - `hit_count` = 0.
  - `predict_valid` = 0.

## Timing
- Pixel-to-accumulator latency is 2 cycles: stage-1 register, then accumulator register.
- `predict_valid` asserts exactly 2 cycles after the `frame_end` cycle and lasts 1 cycle.
- Coordinates and `hit_count` change in the same cycle that `predict_valid` goes high, and are stable for at least a full frame.
- The first pixel of the next frame may arrive 3 cycles after `frame_end` or later; pixels in the 2 cycles after `frame_end` are lost.

## Structure
- Shared package `tracker_pkg` holds:
  - `localparam NOT_FOUND = 11'd2023`.
  - `typedef struct packed { logic [10:0] x, y; } point_t`.
  - A state enum with S_SCAN, S_FLUSH, S_PUBLISH.
- One sub-module, `color_match_stage`: stage-1 registered match classifier with pass-through of x and y, parameterised by the threshold and active-window parameters.

## Test plan
- Reset mid-frame, then release: all outputs are 2023, `predict_valid` stays 0, and no pulse occurs until the next `frame_end`.
- 640×480 frame with a red square (R=255, G=B=0) at x 100–119, y 200–219, then `frame_end`:
  - `predict_valid` pulses at cycle +2.
  - left=(100,200), right=(119,200), up=(100,200), down=(100,219).
  - `hit_count`=400.
- Frame with only 63 red pixels: all coordinates are 2023 and `hit_count`=63; the next frame with 64 pixels publishes real coordinates.
- Red pixel at x=700 and at y=500 (outside the active window), plus a valid 10×10 block: the out-of-window pixels do not affect any extreme and `hit_count`=100.
- Last red pixel (639,479) is driven in the same cycle as `frame_end`: right.x=639 and down=(·,479).
- Second `frame_end` one cycle after the first: exactly one `predict_valid` pulse, and the following frame publishes normally.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types and constants for the colour box tracker.
//   NOT_FOUND : sentinel published for every coordinate when too few pixels match.
//   point_t   : packed (x, y) pixel coordinate used for the working extremes.
//   coord_t   : external coordinate layout, [0]=x, [1]=y.
//   state_e   : frame-level tracker state.
package tracker_pkg;

  localparam logic [10:0] NOT_FOUND = 11'd2023;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } point_t;

  typedef logic [1:0][10:0] coord_t;

  typedef enum logic [1:0] {
    S_SCAN,
    S_FLUSH,
    S_PUBLISH
  } state_e;

  localparam point_t PtNotFound = '{x: NOT_FOUND, y: NOT_FOUND};

  function automatic coord_t to_coord(point_t p);
    coord_t c;
    c[0] = p.x;
    c[1] = p.y;
    return c;
  endfunction

endpackage

// File: rtl/color_match_stage.sv
// Stage-1 registered colour classifier.
//   i_clk, i_rst_n : clock, asynchronous active-low reset.
//   enable_i       : when low the stage captures nothing (register cleared).
//   valid_i        : active pixel qualifier.
//   x_i, y_i       : pixel coordinates.
//   rgb_i          : pixel colour, [0]=R, [1]=G, [2]=B.
//   hit_o          : registered match flag.
//   pt_o           : registered (x, y) of the classified pixel.
module color_match_stage
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [7:0]  R_MIN    = 8'd150,
  parameter logic [7:0]  G_MAX    = 8'd90,
  parameter logic [7:0]  B_MAX    = 8'd90
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            enable_i,
  input  logic            valid_i,
  input  logic [10:0]     x_i,
  input  logic [10:0]     y_i,
  input  logic [2:0][7:0] rgb_i,
  output logic            hit_o,
  output point_t          pt_o
);

  // 12-bit limits so a full 2048-wide window is still expressible.
  localparam logic [11:0] HLimit = 12'(H_ACTIVE);
  localparam logic [11:0] VLimit = 12'(V_ACTIVE);

  logic   hit_d, hit_q;
  point_t pt_d, pt_q;
  logic   in_window, colour_ok;

  always_comb begin
    in_window = ({1'b0, x_i} < HLimit) && ({1'b0, y_i} < VLimit);
    colour_ok = (rgb_i[0] >= R_MIN) && (rgb_i[1] <= G_MAX) && (rgb_i[2] <= B_MAX);
    hit_d     = enable_i & valid_i & in_window & colour_ok;
    pt_d      = enable_i ? '{x: x_i, y: y_i} : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q <= 1'b0;
      pt_q  <= '0;
    end else begin
      hit_q <= hit_d;
      pt_q  <= pt_d;
    end
  end

  assign hit_o = hit_q;
  assign pt_o  = pt_q;

endmodule

// File: rtl/color_box_tracker.sv
// Tracks the leftmost/rightmost/topmost/bottommost target-coloured pixels of each frame
// and publishes them two cycles after frame_end.
//   i_clk, i_rst_n       : clock, asynchronous active-low reset.
//   i_valid, x, y, i_rgb : pixel stream ([0]=R, [1]=G, [2]=B).
//   frame_end            : one-cycle pulse closing the frame (same-cycle pixel included).
//   left/right/up/down   : published extremes, [0]=x, [1]=y; NOT_FOUND when too few hits.
//   predict_valid        : one-cycle pulse when new extremes are published.
//   hit_count            : matching-pixel count of the last published frame.
module color_box_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [7:0]  R_MIN      = 8'd150,
  parameter logic [7:0]  G_MAX      = 8'd90,
  parameter logic [7:0]  B_MAX      = 8'd90,
  parameter logic [19:0] MIN_PIXELS = 20'd64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic [2:0][7:0]  i_rgb,
  input  logic             frame_end,
  output logic [1:0][10:0] left,
  output logic [1:0][10:0] right,
  output logic [1:0][10:0] up,
  output logic [1:0][10:0] down,
  output logic             predict_valid,
  output logic [19:0]      hit_count
);

  localparam point_t LInit = '{x: 11'h7FF, y: 11'd0};
  localparam point_t UInit = '{x: 11'd0, y: 11'h7FF};

  state_e      state_d, state_q;
  logic        s1_hit;
  point_t      s1_pt;
  logic [19:0] cnt_d, cnt_q;
  point_t      l_d, l_q, r_d, r_q, u_d, u_q, dn_d, dn_q;
  point_t      left_d, left_q, right_d, right_q, up_d, up_q, down_d, down_q;
  logic        pv_d, pv_q;
  logic [19:0] hit_count_d, hit_count_q;
  logic        first_hit;

  // Pixels are only admitted while scanning; this also clears stage 1 in S_PUBLISH.
  color_match_stage #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .R_MIN    (R_MIN),
    .G_MAX    (G_MAX),
    .B_MAX    (B_MAX)
  ) u_match (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .enable_i (state_q == S_SCAN),
    .valid_i  (i_valid),
    .x_i      (x),
    .y_i      (y),
    .rgb_i    (i_rgb),
    .hit_o    (s1_hit),
    .pt_o     (s1_pt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_SCAN:    if (frame_end) state_d = S_FLUSH;
      S_FLUSH:   state_d = S_PUBLISH;
      S_PUBLISH: state_d = S_SCAN;
      default:   state_d = S_SCAN;
    endcase
  end

  // Accumulators.
  always_comb begin
    cnt_d     = cnt_q;
    l_d       = l_q;
    r_d       = r_q;
    u_d       = u_q;
    dn_d      = dn_q;
    first_hit = (cnt_q == '0);
    if (state_q == S_PUBLISH) begin
      cnt_d = '0;
      l_d   = LInit;
      r_d   = '0;
      u_d   = UInit;
      dn_d  = '0;
    end else if (s1_hit) begin
      if (cnt_q != '1) cnt_d = cnt_q + 20'd1;
      if (s1_pt.x < l_q.x)                 l_d  = s1_pt;
      if ((s1_pt.x > r_q.x) || first_hit)  r_d  = s1_pt;
      if (s1_pt.y < u_q.y)                 u_d  = s1_pt;
      if ((s1_pt.y > dn_q.y) || first_hit) dn_d = s1_pt;
    end
  end

  // Outputs are loaded on the edge that absorbs the last in-flight pixel (leaving S_FLUSH),
  // using the post-accumulation values, so they appear together with predict_valid in the
  // S_PUBLISH cycle, two cycles after frame_end.
  always_comb begin
    left_d      = left_q;
    right_d     = right_q;
    up_d        = up_q;
    down_d      = down_q;
    hit_count_d = hit_count_q;
    pv_d        = 1'b0;
    if (state_q == S_FLUSH) begin
      pv_d        = 1'b1;
      hit_count_d = cnt_d;
      if (cnt_d >= MIN_PIXELS) begin
        left_d  = l_d;
        right_d = r_d;
        up_d    = u_d;
        down_d  = dn_d;
      end else begin
        left_d  = PtNotFound;
        right_d = PtNotFound;
        up_d    = PtNotFound;
        down_d  = PtNotFound;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_SCAN;
      cnt_q       <= '0;
      l_q         <= LInit;
      r_q         <= '0;
      u_q         <= UInit;
      dn_q        <= '0;
      left_q      <= PtNotFound;
      right_q     <= PtNotFound;
      up_q        <= PtNotFound;
      down_q      <= PtNotFound;
      pv_q        <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      u_q         <= u_d;
      dn_q        <= dn_d;
      left_q      <= left_d;
      right_q     <= right_d;
      up_q        <= up_d;
      down_q      <= down_d;
      pv_q        <= pv_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign left          = to_coord(left_q);
  assign right         = to_coord(right_q);
  assign up            = to_coord(up_q);
  assign down          = to_coord(down_q);
  assign predict_valid = pv_q;
  assign hit_count     = hit_count_q;

endmodule

// File: tb/tb_color_box_tracker.sv
module tb_color_box_tracker;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid, fe;
  logic [10:0]      px, py;
  logic [2:0][7:0]  rgb;
  logic [1:0][10:0] left, right, up, down;
  logic             pv;
  logic [19:0]      hc;

  always #5 clk = ~clk;

  color_box_tracker dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .x             (px),
    .y             (py),
    .i_rgb         (rgb),
    .frame_end     (fe),
    .left          (left),
    .right         (right),
    .up            (up),
    .down          (down),
    .predict_valid (pv),
    .hit_count     (hc)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int x;
    int y;
  } pt_t;

  pt_t   hits[$];
  int    cyc = 0;
  int    pub_cycle = -1;
  int    blk = 0;
  int    exp_c[8];
  int    exp_hc;
  int    pend_c[8];
  int    pend_hc;
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  string cn[8] = '{"left_x", "left_y", "right_x", "right_y",
                   "up_x", "up_y", "down_x", "down_y"};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    hits.delete();
    blk       = 0;
    pub_cycle = -1;
    for (int i = 0; i < 8; i++) exp_c[i] = 2023;
    exp_hc = 0;
  endtask

  // Extremes = first pixel in arrival order reaching the min/max coordinate.
  task automatic model_publish();
    int n;
    int li, ri, ui, di;
    n       = hits.size();
    pend_hc = n;
    if (n < 64) begin
      for (int i = 0; i < 8; i++) pend_c[i] = 2023;
    end else begin
      li = 0; ri = 0; ui = 0; di = 0;
      for (int i = 1; i < n; i++) begin
        if (hits[i].x < hits[li].x) li = i;
        if (hits[i].x > hits[ri].x) ri = i;
        if (hits[i].y < hits[ui].y) ui = i;
        if (hits[i].y > hits[di].y) di = i;
      end
      pend_c = '{hits[li].x, hits[li].y, hits[ri].x, hits[ri].y,
                 hits[ui].x, hits[ui].y, hits[di].x, hits[di].y};
    end
  endtask

  // Drives one cycle of inputs, updates the model, and returns 1 time unit after the edge.
  task automatic drive(input bit v, input int xx, input int yy,
                       input int r, input int g, input int b, input bit f);
    valid  = v;
    px     = 11'(xx);
    py     = 11'(yy);
    rgb[0] = 8'(r);
    rgb[1] = 8'(g);
    rgb[2] = 8'(b);
    fe     = f;
    cyc++;
    if (blk > 0) begin
      blk--;
    end else begin
      if (v && xx < 640 && yy < 480 && r >= 150 && g <= 90 && b <= 90)
        hits.push_back('{xx, yy});
      if (f) begin
        model_publish();
        hits.delete();
        pub_cycle = cyc + 2;
        blk       = 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic red(input int xx, input int yy);
    drive(1, xx, yy, 255, 0, 0, 0);
  endtask

  task automatic red_block(input int x0, input int y0, input int w, input int h);
    for (int yy = y0; yy < y0 + h; yy++)
      for (int xx = x0; xx < x0 + w; xx++) red(xx, yy);
  endtask

  task automatic do_reset(input int n);
    model_reset();
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  // frame_end, then wait into the cycle where the pulse must be visible.
  task automatic end_frame();
    drive(0, 0, 0, 0, 0, 0, 1);
    idle(1);
  endtask

  task automatic chk_pub(input string tag, input int lx, input int ly, input int rx,
                         input int ry, input int ux, input int uy, input int dx,
                         input int dy, input int n);
    chk({tag, "_pv"}, pv, 1);
    chk({tag, "_left_x"}, left[0], lx);
    chk({tag, "_left_y"}, left[1], ly);
    chk({tag, "_right_x"}, right[0], rx);
    chk({tag, "_right_y"}, right[1], ry);
    chk({tag, "_up_x"}, up[0], ux);
    chk({tag, "_up_y"}, up[1], uy);
    chk({tag, "_down_x"}, down[0], dx);
    chk({tag, "_down_y"}, down[1], dy);
    chk({tag, "_hit_count"}, hc, n);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] act[8];
      if (cyc == pub_cycle) begin
        exp_c  = pend_c;
        exp_hc = pend_hc;
      end
      act = '{left[0], left[1], right[0], right[1], up[0], up[1], down[0], down[1]};
      chk("predict_valid", pv, (cyc == pub_cycle) ? 1 : 0);
      for (int i = 0; i < 8; i++) chk(cn[i], act[i], exp_c[i]);
      chk("hit_count", hc, exp_hc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len, gap;
    rst_n = 1'b1;
    valid = 1'b0;
    fe    = 1'b0;
    px    = '0;
    py    = '0;
    rgb   = '0;
    model_reset();
    #1;
    do_reset(3);
    chk_en = 1'b1;
    idle(3);
    chk("rst_left_x", left[0], 2023);
    chk("rst_down_y", down[1], 2023);
    chk("rst_hit_count", hc, 0);

    // Reset in the middle of a frame: accumulated pixels are forgotten.
    red_block(10, 10, 10, 8);
    do_reset(2);
    idle(6);
    end_frame();
    chk_pub("midrst", 2023, 2023, 2023, 2023, 2023, 2023, 2023, 2023, 0);
    idle(1);

    // Red square with non-matching pixels between rows.
    for (int yy = 200; yy < 220; yy++) begin
      for (int xx = 100; xx < 120; xx++) red(xx, yy);
      drive(1, 130, yy, 120, 120, 120, 0);
      drive(1, 90, yy, 149, 0, 0, 0);
    end
    end_frame();
    chk_pub("square", 100, 200, 119, 200, 100, 200, 100, 219, 400);
    idle(1);

    // 63 hits -> not found; 64 hits -> found.
    red_block(10, 5, 63, 1);
    end_frame();
    chk_pub("hits63", 2023, 2023, 2023, 2023, 2023, 2023, 2023, 2023, 63);
    idle(1);
    red_block(10, 5, 64, 1);
    end_frame();
    chk_pub("hits64", 10, 5, 73, 5, 10, 5, 10, 5, 64);
    idle(1);

    // Out-of-window and invalid red pixels are ignored.
    red(700, 10);
    red(10, 500);
    drive(0, 5, 5, 255, 0, 0, 0);
    red_block(50, 60, 10, 10);
    red(640, 61);
    red(55, 480);
    end_frame();
    chk_pub("window", 50, 60, 59, 60, 50, 60, 50, 69, 100);
    idle(1);

    // Last pixel in the frame_end cycle belongs to the frame.
    red_block(600, 470, 8, 8);
    drive(1, 639, 479, 255, 0, 0, 1);
    idle(1);
    chk_pub("lastpx", 600, 470, 639, 479, 600, 470, 639, 479, 65);
    idle(1);

    // Double frame_end: second one ignored, single pulse.
    red_block(200, 100, 64, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk_pub("dblfe", 200, 100, 263, 100, 200, 100, 200, 100, 64);
    idle(1);
    chk("dblfe_no_second_pulse", pv, 0);
    red_block(300, 300, 10, 10);
    end_frame();
    chk_pub("afterdbl", 300, 300, 309, 300, 300, 300, 300, 309, 100);
    idle(1);

    // Randomized frames, including pixels and frame_end inside the blind window.
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(20, 400);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) < 6)
          drive($urandom_range(0, 3) != 0, $urandom_range(0, 799), $urandom_range(0, 599),
                $urandom_range(150, 255), $urandom_range(0, 90), $urandom_range(0, 90), 0);
        else
          drive($urandom_range(0, 3) != 0, $urandom_range(0, 799), $urandom_range(0, 599),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      end
      drive($urandom_range(0, 1), $urandom_range(0, 799), $urandom_range(0, 599),
            $urandom_range(150, 255), $urandom_range(0, 90), $urandom_range(0, 90), 1);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++)
        drive(1, $urandom_range(0, 639), $urandom_range(0, 479), 255, 0, 0,
              $urandom_range(0, 1));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
